// File: rtl/sw_debouncer_if.sv
// Switch/button conditioning bus: raw pad levels in, clean levels and edge pulses out.
interface sw_debouncer_if #(
  parameter int N = 2
);
  logic [N-1:0] sw_raw;
  logic [N-1:0] sw_clean;
  logic [N-1:0] rise;
  logic [N-1:0] fall;

  // The debouncer is the slave; the pin/consumer side is the master.
  modport master (
    output sw_raw,
    input  sw_clean,
    input  rise,
    input  fall
  );

  modport slave (
    input  sw_raw,
    output sw_clean,
    output rise,
    output fall
  );
endinterface

// File: rtl/sw_debouncer.sv
// Per-bit synchronizer plus stability filter for slide switches and push buttons.
// The clean level only moves after STABLE_CYCLES consecutive disagreeing samples.
module sw_debouncer #(
  parameter int N             = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  sw_debouncer_if.slave bus
);

  localparam int CW = ($clog2(STABLE_CYCLES + 1) < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   sync_q;
      logic [CW-1:0]          cnt_reg;
      logic [CW-1:0]          cnt_next;
      logic                   clean_reg;
      logic                   clean_next;
      logic                   rise_reg;
      logic                   rise_next;
      logic                   fall_reg;
      logic                   fall_next;

      assign sync_q = sync_reg[SYNC_STAGES-1];

      // Plain shift chain: nothing may sit between the metastability stages.
      always_ff @(posedge clk) begin
        if (reset) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.sw_raw[gi]};
        end
      end

      // Any agreement with the clean level restarts the stability window.
      always_comb begin
        cnt_next   = cnt_reg;
        clean_next = clean_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        if (sync_q == clean_reg) begin
          cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          clean_next = sync_q;
          rise_next  = sync_q;
          fall_next  = ~sync_q;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg   <= '0;
          clean_reg <= 1'b0;
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
        end else begin
          cnt_reg   <= cnt_next;
          clean_reg <= clean_next;
          rise_reg  <= rise_next;
          fall_reg  <= fall_next;
        end
      end

      assign bus.sw_clean[gi] = clean_reg;
      assign bus.rise[gi]     = rise_reg;
      assign bus.fall[gi]     = fall_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sw_debouncer.sv
// Directed bench for sw_debouncer with N=2, SYNC_STAGES=2, STABLE_CYCLES=4
// (output change lands on edge 6 after a new raw level is first sampled).
module tb_sw_debouncer;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  sw_debouncer_if #(.N(2)) bus ();

  sw_debouncer #(
    .N(2),
    .SYNC_STAGES(2),
    .STABLE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] c, input logic [1:0] r, input logic [1:0] f);
    total++;
    assert (bus.sw_clean === c && bus.rise === r && bus.fall === f)
    else begin
      bad++;
      $error("FAIL %s clean/rise/fall=%b/%b/%b want %b/%b/%b", tag,
             bus.sw_clean, bus.rise, bus.fall, c, r, f);
    end
  endtask

  // Raw input is assumed already changed; walks edges 1..7 and checks each one.
  task automatic expect_change(input string tag, input logic [1:0] old_c, input logic [1:0] new_c,
                               input logic [1:0] r, input logic [1:0] f);
    for (int e = 1; e <= 7; e++) begin
      step();
      if (e < 6)       chk($sformatf("%s_e%0d", tag, e), old_c, 2'b00, 2'b00);
      else if (e == 6) chk($sformatf("%s_e%0d", tag, e), new_c, r, f);
      else             chk($sformatf("%s_e%0d", tag, e), new_c, 2'b00, 2'b00);
    end
  endtask

  initial begin
    logic [1:0] ec;
    logic [1:0] er;

    // 1. reset held 3 cycles with inputs high, then release
    reset      = 1'b1;
    bus.sw_raw = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("reset_%0d", i), 2'b00, 2'b00, 2'b00);
    end
    reset = 1'b0;
    expect_change("rel", 2'b00, 2'b11, 2'b11, 2'b00);

    // 2. clean steps on bit 0: fall then rise
    bus.sw_raw = 2'b10;
    expect_change("fall0", 2'b11, 2'b10, 2'b00, 2'b01);
    bus.sw_raw = 2'b11;
    expect_change("rise0", 2'b10, 2'b11, 2'b01, 2'b00);

    // 3. bounce on bit 1 (first bring it low cleanly)
    bus.sw_raw = 2'b01;
    expect_change("fall1", 2'b11, 2'b01, 2'b00, 2'b10);
    bus.sw_raw = 2'b11; step(); chk("bnc_a", 2'b01, 2'b00, 2'b00);
    bus.sw_raw = 2'b01; step(); chk("bnc_b", 2'b01, 2'b00, 2'b00);
    bus.sw_raw = 2'b11; step(); chk("bnc_c", 2'b01, 2'b00, 2'b00);
    bus.sw_raw = 2'b01; step(); chk("bnc_d", 2'b01, 2'b00, 2'b00);
    bus.sw_raw = 2'b11;
    expect_change("bnc_rise", 2'b01, 2'b11, 2'b10, 2'b00);

    // 4. short glitch on bit 0 is rejected
    bus.sw_raw = 2'b10;
    expect_change("fall0b", 2'b11, 2'b10, 2'b00, 2'b01);
    bus.sw_raw = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("glitch_hi%0d", i), 2'b10, 2'b00, 2'b00);
    end
    bus.sw_raw = 2'b10;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("glitch_lo%0d", i), 2'b10, 2'b00, 2'b00);
    end

    // 5. independent bits, bit 1 starts two edges later
    bus.sw_raw = 2'b00;
    expect_change("fall1b", 2'b10, 2'b00, 2'b00, 2'b10);
    bus.sw_raw = 2'b01;
    for (int e = 1; e <= 9; e++) begin
      step();
      if (e == 2) bus.sw_raw = 2'b11;
      ec = {(e >= 8) ? 1'b1 : 1'b0, (e >= 6) ? 1'b1 : 1'b0};
      er = {(e == 8) ? 1'b1 : 1'b0, (e == 6) ? 1'b1 : 1'b0};
      chk($sformatf("indep_e%0d", e), ec, er, 2'b00);
    end

    // 6. reset in the middle of a count
    bus.sw_raw = 2'b00;
    expect_change("fall_both", 2'b11, 2'b00, 2'b00, 2'b11);
    bus.sw_raw = 2'b01;
    for (int e = 1; e <= 3; e++) begin
      step();
      chk($sformatf("mid_e%0d", e), 2'b00, 2'b00, 2'b00);
    end
    reset = 1'b1;
    step();
    chk("mid_reset", 2'b00, 2'b00, 2'b00);
    reset = 1'b0;
    expect_change("after_rst", 2'b00, 2'b01, 2'b01, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
